dlfloat16_simd_sub_seq: RTL and testbench

//  Lane sequencer that feeds a single combinational DLFloat16 subtractor and collects its results.

---
 rtl/dlf16_pkg.sv | 24 ++
 rtl/dlfloat16_simd_sub_seq_if.sv | 39 +++
 rtl/dlf16_lane_flags.sv | 14 +
 rtl/dlfloat16_simd_sub_seq.sv | 101 ++++++++++
 tb/tb_dlfloat16_simd_sub_seq.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dlf16_pkg.sv
// Shared DLFloat16 types and constants for the lane sequencer and its flag decoder.
package dlf16_pkg;

  typedef logic [15:0] dlf16_t;

  localparam dlf16_t DLF16_NAN     = 16'hFFFF;
  localparam dlf16_t DLF16_MAX_POS = 16'h7DFE;
  localparam dlf16_t DLF16_MAX_NEG = 16'hFDFE;
  localparam dlf16_t DLF16_ONE     = 16'h3E00;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

  // Field order gives the {nan,sat,zero} packing used on out_flags.
  typedef struct packed {
    logic nan;
    logic sat;
    logic zero;
  } lane_flags_t;

endpackage

// File: rtl/dlfloat16_simd_sub_seq_if.sv
// Operand/result vector handshake bundle for dlfloat16_simd_sub_seq.
// out_flags exists only when DLF_SUB_FLAGS_EN is defined.
interface dlfloat16_simd_sub_seq_if #(
  parameter int LANES = 4
);

  logic                in_valid;
  logic                in_ready;
  logic [16*LANES-1:0] in_a;
  logic [16*LANES-1:0] in_b;
  logic                out_valid;
  logic                out_ready;
  logic [16*LANES-1:0] out_diff;

`ifdef DLF_SUB_FLAGS_EN
  logic [3*LANES-1:0]  out_flags;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_diff, out_flags
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_diff, out_flags
  );
`else
  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_diff
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_diff
  );
`endif

endinterface

// File: rtl/dlf16_lane_flags.sv
// Combinational {nan,sat,zero} classification of one DLFloat16 value.
module dlf16_lane_flags
  import dlf16_pkg::*;
(
  input  dlf16_t      value,
  output lane_flags_t flags
);

  assign flags.nan  = (value == DLF16_NAN);
  assign flags.sat  = (value == DLF16_MAX_POS) || (value == DLF16_MAX_NEG);
  // Both signed zeros count as zero.
  assign flags.zero = (value[14:0] == 15'd0);

endmodule

// File: rtl/dlfloat16_simd_sub_seq.sv
// Serialises a LANES-wide DLFloat16 operand vector through one external subtractor.
// Define DLF_SUB_FLAGS_EN to add registered per-lane {nan,sat,zero} flags on out_flags.
module dlfloat16_simd_sub_seq
  import dlf16_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic   clk,
  input  logic   rst_n,
  dlfloat16_simd_sub_seq_if.slave bus,
  output dlf16_t sub_a,
  output dlf16_t sub_b,
  input  dlf16_t sub_diff,
  output logic   busy
);

  localparam int CNT_W = $clog2(LANES);

  seq_state_t              state;
  logic [CNT_W-1:0]        lane_cnt;
  dlf16_t [LANES-1:0]      a_reg;
  dlf16_t [LANES-1:0]      b_reg;
  dlf16_t [LANES-1:0]      diff_reg;
  logic                    last_lane;

  assign last_lane = (lane_cnt == CNT_W'(LANES - 1));

  // NOTE: operand and result registers take a reset value like the control
  // state, so an aborted vector never leaves stale lanes visible on out_diff.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      lane_cnt <= '0;
      a_reg    <= '0;
      b_reg    <= '0;
      diff_reg <= '0;
    end else begin
      // NOTE: non-blocking updates keep every register sampling pre-edge values.
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_reg    <= bus.in_a;
            b_reg    <= bus.in_b;
            lane_cnt <= '0;
            state    <= RUN;
          end
        end
        RUN: begin
          diff_reg[lane_cnt] <= sub_diff;
          if (last_lane) begin
            lane_cnt <= '0;
            state    <= DONE;
          end else begin
            lane_cnt <= lane_cnt + CNT_W'(1);
          end
        end
        DONE: begin
          if (bus.out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: defaults first so the RUN-only mux cannot infer a latch.
  always_comb begin
    sub_a = '0;
    sub_b = '0;
    if (state == RUN) begin
      sub_a = a_reg[lane_cnt];
      sub_b = b_reg[lane_cnt];
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.out_diff  = diff_reg;
  assign busy          = (state != IDLE);

`ifdef DLF_SUB_FLAGS_EN
  lane_flags_t              flags_now;
  lane_flags_t [LANES-1:0]  flags_reg;

  dlf16_lane_flags u_lane_flags (
    .value (sub_diff),
    .flags (flags_now)
  );

  // Flags are captured on the same edge as their lane's difference.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_reg <= '0;
    end else if (state == RUN) begin
      flags_reg[lane_cnt] <= flags_now;
    end
  end

  assign bus.out_flags = flags_reg;
`endif

endmodule

// File: tb/tb_dlfloat16_simd_sub_seq.sv
// Scoreboard bench for dlfloat16_simd_sub_seq with a real-arithmetic DLFloat16 subtractor model.
module tb_dlfloat16_simd_sub_seq;
  import dlf16_pkg::*;

  localparam int LANES = 4;
  localparam int VW    = 16 * LANES;

  typedef logic [VW-1:0] vec_t;
  typedef struct {
    vec_t                 diff;
    logic [3*LANES-1:0]   flags;
  } exp_t;

  logic   clk   = 1'b0;
  logic   rst_n = 1'b0;
  dlf16_t sub_a;
  dlf16_t sub_b;
  dlf16_t sub_diff;
  logic   busy;

  int     n_vec  = 0;
  int     n_miss = 0;
  exp_t   exp_q[$];

  always #5 clk = ~clk;

  dlfloat16_simd_sub_seq_if #(.LANES(LANES)) bus ();

  dlfloat16_simd_sub_seq #(.LANES(LANES)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .sub_a    (sub_a),
    .sub_b    (sub_b),
    .sub_diff (sub_diff),
    .busy     (busy)
  );

  // DLFloat16: 1 sign, 6 exponent (bias 31), 9 fraction bits, no subnormals.
  function automatic real dlf_val(input dlf16_t x);
    real m;
    int  e;
    if (x[14:0] == 15'd0) return 0.0;
    e = int'(x[14:9]) - 31;
    m = 1.0 + real'(x[8:0]) / 512.0;
    while (e > 0) begin m = m * 2.0; e--; end
    while (e < 0) begin m = m / 2.0; e++; end
    return x[15] ? -m : m;
  endfunction

  function automatic dlf16_t dlf_enc(input real v);
    real  mag;
    int   e;
    int   mi;
    logic s;
    if (v == 0.0) return 16'h0000;
    s   = (v < 0.0);
    mag = s ? -v : v;
    e   = 31;
    while (mag >= 2.0) begin mag = mag / 2.0; e++; end
    while (mag < 1.0)  begin mag = mag * 2.0; e--; end
    mi = int'((mag - 1.0) * 512.0);
    if (mi == 512) begin mi = 0; e++; end
    if (e > 62 || (e == 62 && mi > 510)) return {s, 15'h7DFE};
    if (e < 1) return 16'h0000;
    return {s, 6'(e), 9'(mi)};
  endfunction

  function automatic dlf16_t dlf_sub(input dlf16_t a, input dlf16_t b);
    if (a == DLF16_NAN || b == DLF16_NAN) return DLF16_NAN;
    return dlf_enc(dlf_val(a) - dlf_val(b));
  endfunction

  function automatic exp_t model(input vec_t a, input vec_t b);
    exp_t   r;
    dlf16_t d;
    for (int i = 0; i < LANES; i++) begin
      d = dlf_sub(a[16*i +: 16], b[16*i +: 16]);
      r.diff[16*i +: 16] = d;
      r.flags[3*i +: 3]  = {d == DLF16_NAN,
                            (d == DLF16_MAX_POS) || (d == DLF16_MAX_NEG),
                            d[14:0] == 15'd0};
    end
    return r;
  endfunction

  function automatic dlf16_t rand_op();
    case ($urandom_range(0, 9))
      0:       return DLF16_NAN;
      1:       return DLF16_MAX_POS;
      2:       return DLF16_MAX_NEG;
      3:       return DLF16_ONE;
      4:       return 16'h0000;
      default: return 16'($urandom);
    endcase
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    for (int i = 0; i < LANES; i++) v[16*i +: 16] = rand_op();
    return v;
  endfunction

  always_comb sub_diff = dlf_sub(sub_a, sub_b);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare every accepted result vector against the scoreboard head.
  always @(negedge clk) begin
    exp_t e;
    #1;
    if (rst_n && bus.out_valid && bus.out_ready) begin
      check("scoreboard_nonempty", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("out_diff", bus.out_diff, e.diff);
`ifdef DLF_SUB_FLAGS_EN
        check("out_flags", 64'(bus.out_flags), 64'(e.flags));
`endif
      end
    end
  end

  // Called at a negedge; returns at the negedge following the accepting edge.
  task automatic send(input vec_t a, input vec_t b);
    int n = 0;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("accept_timeout", bus.in_ready, 1'b1);
    if (bus.in_ready) exp_q.push_back(model(a, b));
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_a     = rand_vec();
    bus.in_b     = rand_vec();
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!bus.out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("valid_timeout", bus.out_valid, 1'b1);
  endtask

  // Drains the current vector; returns at the negedge after the output handshake.
  task automatic wait_done(input bit rand_bp);
    int n    = 0;
    bit done = 1'b0;
    while (!done && n < 200) begin
      bus.out_ready = rand_bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (bus.out_valid && bus.out_ready) done = 1'b1;
      @(negedge clk);
      n++;
    end
    check("done_timeout", done, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got time %0t, expected < 200000", $time);
    $fatal(1);
  end

  initial begin
    vec_t va, vb, v2a, v2b;
    exp_t e;

    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b0;

    // Reset values
    @(negedge clk);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_in_ready",  bus.in_ready,  1'b1);
    check("rst_busy",      busy,          1'b0);
    check("rst_out_diff",  bus.out_diff,  64'd0);
    check("rst_sub_a",     sub_a,         16'd0);
    check("rst_sub_b",     sub_b,         16'd0);
`ifdef DLF_SUB_FLAGS_EN
    check("rst_out_flags", 64'(bus.out_flags), 64'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic subtract: 2.0 - 1.0 on every lane, lane walk and latency
    bus.out_ready = 1'b1;
    va = {4{16'h4000}};
    vb = {4{16'h3E00}};
    send(va, vb);
    for (int i = 0; i < LANES; i++) begin
      check("walk_sub_a",     sub_a,         va[16*i +: 16]);
      check("walk_sub_b",     sub_b,         vb[16*i +: 16]);
      check("early_valid",    bus.out_valid, 1'b0);
      @(negedge clk);
    end
    check("latency_valid",    bus.out_valid, 1'b1);
    check("basic_diff",       bus.out_diff,  {4{16'h3E00}});
    check("done_sub_a_zero",  sub_a,         16'd0);
    check("done_in_ready",    bus.in_ready,  1'b0);
    @(negedge clk);
    check("return_in_ready",  bus.in_ready,  1'b1);
    check("return_valid_low", bus.out_valid, 1'b0);

    // Backpressure with a competing input vector
    bus.out_ready = 1'b0;
    va = rand_vec();
    vb = rand_vec();
    e  = model(va, vb);
    send(va, vb);
    wait_valid();
    v2a = rand_vec();
    v2b = rand_vec();
    bus.in_a     = v2a;
    bus.in_b     = v2b;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      check("bp_valid",    bus.out_valid, 1'b1);
      check("bp_diff",     bus.out_diff,  e.diff);
      check("bp_in_ready", bus.in_ready,  1'b0);
      check("bp_busy",     busy,          1'b1);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    send(v2a, v2b);
    wait_done(1'b0);

    // Reset while lane_cnt == 2
    va = rand_vec();
    vb = rand_vec();
    send(va, vb);
    @(negedge clk);
    @(negedge clk);
    check("mid_lane2_sub_a", sub_a, va[32 +: 16]);
    #2 rst_n = 1'b0;
    #1;
    check("abort_out_valid", bus.out_valid, 1'b0);
    check("abort_in_ready",  bus.in_ready,  1'b1);
    check("abort_busy",      busy,          1'b0);
    check("abort_sub_a",     sub_a,         16'd0);
    check("abort_out_diff",  bus.out_diff,  64'd0);
    if (exp_q.size() != 0) void'(exp_q.pop_back());
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(rand_vec(), rand_vec());
    wait_done(1'b0);

    // Flag lanes: NaN, exact zero, saturation
    va = {16'h4000, DLF16_MAX_POS, DLF16_ONE, DLF16_NAN};
    vb = {DLF16_ONE, DLF16_MAX_NEG, DLF16_ONE, DLF16_ONE};
    send(va, vb);
    wait_valid();
    check("flag_vec_diff", bus.out_diff, {16'h3E00, 16'h7DFE, 16'h0000, 16'hFFFF});
`ifdef DLF_SUB_FLAGS_EN
    check("flag_vec_flags", 64'(bus.out_flags[8:0]), 64'({3'b010, 3'b001, 3'b100}));
`endif
    wait_done(1'b0);

    // Mixed lanes, no crossover
    va = {16'h4000, 16'h3E00, 16'h0000, 16'hFFFF};
    vb = {16'h3E00, 16'h4000, 16'h0000, 16'h3E00};
    send(va, vb);
    wait_valid();
    check("mixed_diff", bus.out_diff, {16'h3E00, 16'hBE00, 16'h0000, 16'hFFFF});
    wait_done(1'b0);

    // Randomized vectors with random backpressure and gaps
    for (int k = 0; k < 40; k++) begin
      send(rand_vec(), rand_vec());
      wait_done(1'b1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
